pipe_start_sched: RTL and testbench
===================================

# pipe_start_sched

Event scheduler for the TE→TC chain. It accepts `done_in` pulses and BX tags from an upstream HLS stage and holds up to DEPTH events in flight. Each event waits a programmed latency, then the block issues `start_out` with the matching BX to the downstream stage when that stage signals `ready_in`. Fixed-latency pipe delays realign the data paths; this block keeps the control sequence aligned with them.

## Interface
- BXW, 3: BX tag width.
- DEPTH, 4: events in flight; power of two, ≥2.
- CNTW, 10: latency counter width.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  accept enable; when low, `done_in` is ignored and queued events still drain.
- delay  in  CNTW  programmed latency D in cycles; captured into `delay_r` only while idle.
- done_in  in  1  upstream event pulse, sampled every edge.
- bx_in  in  BXW  BX tag qualified by `done_in`.
- ready_in  in  1  downstream can take a start this cycle.
- start_out  out  1  one-cycle registered start pulse to downstream.
- bx_out  out  BXW  BX of the issued event; held until the next issue.
- pending  out  log2(DEPTH)+1  number of queued events.
- overflow  out  1  sticky; an event was dropped.
- bx_err  out  1  sticky BX sequence error (see Configuration).

## Operation
- Queue: circular buffer of DEPTH slots, each holding {bx, cnt[CNTW-1:0]}, with write pointer, read pointer and occupancy counter.
- Push: on an edge where `en & done_in`, write {bx_in, delay_r} at the write pointer.
- Countdown: every edge, each occupied slot with cnt>0 decrements by 1; cnt holds at 0.
- Pop/issue: on an edge where occupancy>0, head cnt==0 and `ready_in`=1:
  - `start_out`←1, `bx_out`←head bx, read pointer advances.
  - On every other edge `start_out`←0.
- Ordering: all queued entries share `delay_r`, so they mature in FIFO order. At most one issue per cycle. A matured head waits indefinitely for `ready_in`, while the entries behind it keep counting down.
- Delay capture: `delay_r`←`delay` on an edge where occupancy==0 and no push occurs. Otherwise `delay_r` holds. A change to `delay` mid-run takes effect only after the queue drains.
- Full:
  - Push with occupancy==DEPTH and no pop on the same edge: the event is dropped, `overflow`←1 (sticky until reset).
  - Push and pop on the same edge while full: the push is accepted and occupancy stays DEPTH.
- Simultaneous push and pop at any occupancy: occupancy is unchanged and both pointers advance.
- Empty: no issue; `bx_out` holds its last value.
- Pointers wrap modulo DEPTH.
- Reset (asynchronous, at any time including mid-operation):
  - Queue emptied, pointers 0, occupancy 0, `delay_r`=0.
  - `start_out`=0, `bx_out`=0, `pending`=0, `overflow`=0, `bx_err`=0.
  - In-flight events are discarded and no start is issued for them.

## Timing
- Latency: with `done_in` sampled at edge 0, `delay_r`=D and `ready_in` held high, `start_out` is high in the cycle after edge D+1.
  - D=0 gives 1-cycle latency.
  - D=2^CNTW−1 is the maximum.
- `ready_in` low at the maturity edge postpones the issue to the first later edge with `ready_in`=1.
- `pending` is registered and reflects pushes and pops of the previous edge.
- Back-to-back `done_in` on consecutive cycles produces back-to-back `start_out` pulses D+1 cycles later, provided DEPTH ≥ min(D+1, event burst).

## Configuration
- `PIPE_START_SCHED_BXCHK_EN` defined:
  - Each accepted push compares `bx_in` with (last accepted bx + 1) mod 2^BXW.
  - A mismatch sets `bx_err` (sticky until reset).
  - The first push after reset only records its bx.
  - Dropped events are not checked.
- Not defined: `bx_err` is tied to 0 and the checking logic is absent.

## Test plan
- Reset, `delay`=5, single `done_in` with `bx_in`=3, `ready_in`=1 → one `start_out` pulse 6 cycles later, `bx_out`=3, `pending` goes 1 then 0.
- `delay`=10, `done_in` every cycle for 4 cycles, bx 0..3, DEPTH=4 → starts on 4 consecutive cycles beginning 11 cycles after the first, bx 0,1,2,3; `overflow`=0.
- `delay`=10, 5 consecutive `done_in` → fifth event dropped, `overflow`=1, only 4 starts issued.
- `delay`=2, one event, `ready_in` low for 7 cycles after maturity → `start_out` on the first edge after `ready_in` rises, exactly one pulse.
- `delay` changed from 4 to 8 while 2 events are queued → both queued events use 4; the next event after drain uses 8. Assert reset mid-countdown → `pending`=0 and no start is ever issued for the queued events.
- With `PIPE_START_SCHED_BXCHK_EN` defined, pushes with bx 6,7,0,2 → `bx_err` rises after bx 2 and stays high. Without the macro → `bx_err`=0.

Source files
------------

// File: rtl/pipe_start_sched.sv
// rtl/pipe_start_sched.sv - fixed-latency start scheduler for the TE->TC control chain
// Optional BX sequence checker enabled by defining PIPE_START_SCHED_BXCHK_EN.
module pipe_start_sched #(
    parameter int BXW   = 3,
    parameter int DEPTH = 4,
    parameter int CNTW  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [CNTW-1:0]          delay,
    input  logic                     done_in,
    input  logic [BXW-1:0]           bx_in,
    input  logic                     ready_in,
    output logic                     start_out,
    output logic [BXW-1:0]           bx_out,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic                     bx_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [BXW-1:0]  r_bx  [DEPTH];
    logic [CNTW-1:0] r_cnt [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_occ;
    logic [CNTW-1:0] r_delay;
    logic            r_start;
    logic [BXW-1:0]  r_bx_out;
    logic            r_ovf;

    logic w_push_req;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign w_push_req = en & done_in;
    assign w_pop      = (r_occ != '0) && (r_cnt[r_rd] == '0) && ready_in;
    assign w_full     = (r_occ == OCC_FULL);
    // A pop frees the head slot on the same edge, so a full queue can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bx[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr == AW'(i))) begin
                    r_bx[i]  <= bx_in;
                    r_cnt[i] <= r_delay;
                    r_vld[i] <= 1'b1;
                end else begin
                    if (w_pop && (r_rd == AW'(i)))
                        r_vld[i] <= 1'b0;
                    if (r_vld[i] && (r_cnt[i] != '0))
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_occ    <= '0;
            r_delay  <= '0;
            r_start  <= 1'b0;
            r_bx_out <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd     <= r_rd + 1'b1;
                r_bx_out <= r_bx[r_rd];
            end
            r_start <= w_pop;
            if (w_push && !w_pop)
                r_occ <= r_occ + 1'b1;
            else if (!w_push && w_pop)
                r_occ <= r_occ - 1'b1;
            // Latency is only re-sampled while idle so queued events share one delay.
            if ((r_occ == '0) && !w_push_req)
                r_delay <= delay;
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

`ifdef PIPE_START_SCHED_BXCHK_EN
    logic [BXW-1:0] r_bx_last;
    logic           r_bx_seen;
    logic           r_bx_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bx_last <= '0;
            r_bx_seen <= 1'b0;
            r_bx_err  <= 1'b0;
        end else if (w_push) begin
            r_bx_last <= bx_in;
            r_bx_seen <= 1'b1;
            if (r_bx_seen && (bx_in != BXW'(r_bx_last + 1'b1)))
                r_bx_err <= 1'b1;
        end
    end

    assign bx_err = r_bx_err;
`else
    assign bx_err = 1'b0;
`endif

    assign start_out = r_start;
    assign bx_out    = r_bx_out;
    assign pending   = r_occ;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipe_start_sched.sv
// tb/tb_pipe_start_sched.sv - self-checking bench for pipe_start_sched
// Event-time reference model plus directed literal checks and a randomized phase.
module tb_pipe_start_sched;
    localparam int BXW   = 3;
    localparam int DEPTH = 4;
    localparam int CNTW  = 10;
`ifdef PIPE_START_SCHED_BXCHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [CNTW-1:0] delay;
    logic            done_in;
    logic [BXW-1:0]  bx_in;
    logic            ready_in;
    logic            start_out;
    logic [BXW-1:0]  bx_out;
    logic [$clog2(DEPTH):0] pending;
    logic            overflow;
    logic            bx_err;

    int errors = 0;
    int checks = 0;

    pipe_start_sched #(.BXW(BXW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .en(en), .delay(delay), .done_in(done_in),
        .bx_in(bx_in), .ready_in(ready_in), .start_out(start_out), .bx_out(bx_out),
        .pending(pending), .overflow(overflow), .bx_err(bx_err)
    );

    always #5 clk = ~clk;

    // Each event is stored with the absolute edge at which it may issue.
    typedef struct {
        logic [BXW-1:0] bx;
        longint         due;
    } ev_t;

    ev_t            q[$];
    ev_t            ev;
    longint         n = 0;
    longint         m_delay = 0;
    bit             m_start = 0;
    logic [BXW-1:0] m_bx = '0;
    bit             m_ovf = 0;
    bit             m_err = 0;
    bit             m_seen = 0;
    logic [BXW-1:0] m_last = '0;
    int             m_pending = 0;
    bit             mp_pop, mp_req, mp_acc;
    int             mp_sz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_delay = 0; m_start = 0; m_bx = '0; m_ovf = 0;
            m_err = 0; m_seen = 0; m_last = '0; m_pending = 0;
        end else begin
            n++;
            mp_sz  = q.size();
            mp_pop = (mp_sz > 0) && (q[0].due <= n) && (ready_in === 1'b1);
            mp_req = (en === 1'b1) && (done_in === 1'b1);
            mp_acc = mp_req && ((mp_sz < DEPTH) || mp_pop);
            if (mp_req && !mp_acc) m_ovf = 1;
            if (mp_pop) begin
                m_start = 1;
                m_bx = q[0].bx;
                void'(q.pop_front());
            end else begin
                m_start = 0;
            end
            if (mp_acc) begin
                ev.bx  = bx_in;
                ev.due = n + m_delay + 1;
                q.push_back(ev);
                if (m_seen && (bx_in != BXW'(m_last + 1))) m_err = 1;
                m_last = bx_in;
                m_seen = 1;
            end
            if ((mp_sz == 0) && !mp_req) m_delay = longint'(delay);
            m_pending = q.size();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("start_out", 32'(start_out), 32'(m_start));
        check("bx_out",    32'(bx_out),    32'(m_bx));
        check("pending",   32'(pending),   32'(m_pending));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("bx_err",    32'(bx_err),    32'(CHK ? m_err : 1'b0));
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        done_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_pending",  32'(pending),   0);
        check("rst_start",    32'(start_out), 0);
        check("rst_bx_out",   32'(bx_out),    0);
        check("rst_overflow", 32'(overflow),  0);
        check("rst_bx_err",   32'(bx_err),    0);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input logic [BXW-1:0] b);
        done_in = 1'b1;
        bx_in   = b;
        tick();
        done_in = 1'b0;
    endtask

    int sc;
    logic [BXW-1:0] rb;

    initial begin
        reset = 1'b1; en = 1'b0; delay = '0; done_in = 1'b0; bx_in = '0; ready_in = 1'b0;

        // single event, D=5
        do_reset();
        en = 1'b1; ready_in = 1'b1; delay = 10'd5;
        tick();
        push(3'd3);
        check("t1_pend1", 32'(pending), 1);
        repeat (5) tick();
        check("t1_early", 32'(start_out), 0);
        tick();
        check("t1_start", 32'(start_out), 1);
        check("t1_bx",    32'(bx_out), 3);
        check("t1_pend0", 32'(pending), 0);
        tick();
        check("t1_once",  32'(start_out), 0);

        // burst of four at D=10
        delay = 10'd10;
        tick();
        for (int k = 0; k < 4; k++) push(BXW'(k));
        repeat (7) tick();
        check("t2_early", 32'(start_out), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_start", 32'(start_out), 1);
            check("t2_bx",    32'(bx_out), k);
        end
        check("t2_ovf", 32'(overflow), 0);

        // five pushes into depth four
        do_reset();
        delay = 10'd10;
        tick();
        for (int k = 0; k < 5; k++) push(BXW'(k));
        check("t3_ovf", 32'(overflow), 1);
        sc = 0;
        repeat (20) begin tick(); sc += int'(start_out); end
        check("t3_starts", 32'(sc), 4);

        // matured head stalled by ready_in
        do_reset();
        delay = 10'd2;
        tick();
        push(3'd5);
        ready_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t4_stall", 32'(start_out), 0);
        end
        ready_in = 1'b1;
        tick();
        check("t4_start", 32'(start_out), 1);
        check("t4_bx",    32'(bx_out), 5);
        tick();
        check("t4_once",  32'(start_out), 0);

        // delay change while queued, then reset mid-countdown
        do_reset();
        delay = 10'd4;
        tick();
        push(3'd1);
        push(3'd2);
        delay = 10'd8;
        repeat (3) tick();
        check("t5_early", 32'(start_out), 0);
        tick();
        check("t5_s1", 32'(start_out), 1);
        check("t5_b1", 32'(bx_out), 1);
        tick();
        check("t5_s2", 32'(start_out), 1);
        check("t5_b2", 32'(bx_out), 2);
        tick();
        push(3'd3);
        repeat (8) tick();
        check("t5_early8", 32'(start_out), 0);
        tick();
        check("t5_s3", 32'(start_out), 1);
        check("t5_b3", 32'(bx_out), 3);
        push(3'd4);
        push(3'd5);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 check("t5_rst_pend", 32'(pending), 0);
        tick();
        #1 reset = 1'b0;
        sc = 0;
        repeat (30) begin tick(); sc += int'(start_out); end
        check("t5_no_start", 32'(sc), 0);

        // BX sequence 6,7,0,2
        do_reset();
        delay = 10'd0;
        tick();
        push(3'd6);
        push(3'd7);
        push(3'd0);
        check("t6_err_clean", 32'(bx_err), 0);
        push(3'd2);
        check("t6_err_set", 32'(bx_err), 32'(CHK));
        repeat (5) tick();
        check("t6_err_sticky", 32'(bx_err), 32'(CHK));

        // maximum latency
        do_reset();
        delay = 10'd1023;
        tick();
        push(3'd4);
        repeat (1023) tick();
        check("t7_early", 32'(start_out), 0);
        tick();
        check("t7_start", 32'(start_out), 1);
        check("t7_bx",    32'(bx_out), 4);

        // randomized traffic
        do_reset();
        rb = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            en       = ($urandom_range(0, 7) != 0);
            done_in  = ($urandom_range(0, 2) != 0);
            rb       = ($urandom_range(0, 9) == 0) ? BXW'($urandom) : BXW'(rb + 1'b1);
            bx_in    = rb;
            ready_in = ($urandom_range(0, 3) != 0);
            delay    = ($urandom_range(0, 15) == 0) ? CNTW'($urandom_range(0, 40))
                                                    : CNTW'($urandom_range(0, 5));
            tick();
        end
        done_in = 1'b0;
        repeat (60) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
